decode_issue_stage: RTL and testbench

Registered, parametrised instruction-decode and issue stage for the RV32I+XMM core. It sits between fetch and execute, turning a 32-bit instruction word into the full control bundle: memory and register-file write enables, ALU/FPU/write-back source selects, and register addresses. It adds a valid/ready handshake, a one-entry output register, an illegal-instruction flag, flush, and a pending-write scoreboard for the integer (x) and floating-point (xmm) register files that stalls issue on RAW and WAW hazards.

---
 rtl/ctrl_pkg.sv | 62 ++++++
 rtl/instr_ctrl_decode.sv | 127 ++++++++++++
 rtl/decode_issue_stage.sv | 155 +++++++++++++++
 tb/tb_decode_issue_stage.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared control encodings and the decoded control bundle for the decode/issue stage.
package ctrl_pkg;

  // Major opcodes, instr[6:2]
  localparam logic [4:0] OP_LOAD     = 5'h00;
  localparam logic [4:0] OP_LOAD_FP  = 5'h01;
  localparam logic [4:0] OP_MISC_MEM = 5'h03;
  localparam logic [4:0] OP_OP_IMM   = 5'h04;
  localparam logic [4:0] OP_AUIPC    = 5'h05;
  localparam logic [4:0] OP_STORE    = 5'h08;
  localparam logic [4:0] OP_STORE_FP = 5'h09;
  localparam logic [4:0] OP_OP       = 5'h0c;
  localparam logic [4:0] OP_LUI      = 5'h0d;
  localparam logic [4:0] OP_OP_FP    = 5'h14;
  localparam logic [4:0] OP_BRANCH   = 5'h18;
  localparam logic [4:0] OP_JALR     = 5'h19;
  localparam logic [4:0] OP_JAL      = 5'h1b;

  localparam logic [2:0] ALU_SRC_ZERO     = 3'd0;
  localparam logic [2:0] ALU_SRC_REG      = 3'd1;
  localparam logic [2:0] ALU_SRC_IMM12    = 3'd2;
  localparam logic [2:0] ALU_SRC_IMM20    = 3'd3;
  localparam logic [2:0] ALU_SRC_PC       = 3'd4;
  localparam logic [2:0] ALU_SRC_PC_PLUS4 = 3'd5;

  localparam logic [1:0] FPU_SRC_ZERO = 2'd0;
  localparam logic [1:0] FPU_SRC_XMM  = 2'd1;
  localparam logic [1:0] FPU_SRC_ONE  = 2'd2;

  localparam logic [2:0] REG_WRITE_SRC_NONE = 3'd0;
  localparam logic [2:0] REG_WRITE_SRC_ALU  = 3'd1;
  localparam logic [2:0] REG_WRITE_SRC_MEM  = 3'd2;

  localparam logic [2:0] XMM_WRITE_SRC_NONE = 3'd0;
  localparam logic [2:0] XMM_WRITE_SRC_FPU  = 3'd1;
  localparam logic [2:0] XMM_WRITE_SRC_MEM  = 3'd2;

  localparam logic [1:0] MEM_WRITE_SRC_NONE = 2'd0;
  localparam logic [1:0] MEM_WRITE_SRC_REG  = 2'd1;
  localparam logic [1:0] MEM_WRITE_SRC_XMM  = 2'd2;

  typedef struct packed {
    logic       read_mem;
    logic       write_mem;
    logic       write_reg;
    logic       write_xmm;
    logic       illegal;
    logic [2:0] alu_a_src;
    logic [2:0] alu_b_src;
    logic [1:0] fpu_a_src;
    logic [1:0] fpu_b_src;
    logic [1:0] fpu_c_src;
    logic [2:0] reg_write_src;
    logic [2:0] xmm_write_src;
    logic [1:0] mem_write_src;
  } ctrl_bundle_t;

  function automatic logic is_fp_opcode(input logic [4:0] op);
    return (op == OP_LOAD_FP) || (op == OP_STORE_FP) || (op == OP_OP_FP);
  endfunction

endpackage

// File: rtl/instr_ctrl_decode.sv
// Combinational opcode decoder: produces the control bundle and register-read flags.
module instr_ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit FP_EN = 1'b1
) (
  input  logic [6:0]   opcode,
  output ctrl_bundle_t ctrl,
  output logic         use_x_rs1,
  output logic         use_x_rs2,
  output logic         use_xmm_rs1,
  output logic         use_xmm_rs2
);

  always_comb begin
    ctrl        = '0;
    use_x_rs1   = 1'b0;
    use_x_rs2   = 1'b0;
    use_xmm_rs1 = 1'b0;
    use_xmm_rs2 = 1'b0;
    if (opcode[1:0] != 2'b11) begin
      ctrl.illegal = 1'b1;
    end else begin
      case (opcode[6:2])
        OP_LOAD: begin
          ctrl.read_mem      = 1'b1;
          ctrl.write_reg     = 1'b1;
          ctrl.reg_write_src = REG_WRITE_SRC_MEM;
          ctrl.alu_a_src     = ALU_SRC_REG;
          ctrl.alu_b_src     = ALU_SRC_IMM12;
          use_x_rs1          = 1'b1;
        end
        OP_LOAD_FP: begin
          ctrl.read_mem      = 1'b1;
          ctrl.write_xmm     = 1'b1;
          ctrl.xmm_write_src = XMM_WRITE_SRC_MEM;
          ctrl.alu_a_src     = ALU_SRC_REG;
          ctrl.alu_b_src     = ALU_SRC_IMM12;
          use_x_rs1          = 1'b1;
        end
        OP_MISC_MEM: ;
        OP_OP_IMM: begin
          ctrl.write_reg     = 1'b1;
          ctrl.reg_write_src = REG_WRITE_SRC_ALU;
          ctrl.alu_a_src     = ALU_SRC_REG;
          ctrl.alu_b_src     = ALU_SRC_IMM12;
          use_x_rs1          = 1'b1;
        end
        OP_AUIPC: begin
          ctrl.write_reg     = 1'b1;
          ctrl.reg_write_src = REG_WRITE_SRC_ALU;
          ctrl.alu_a_src     = ALU_SRC_PC;
          ctrl.alu_b_src     = ALU_SRC_IMM20;
        end
        OP_STORE: begin
          ctrl.write_mem     = 1'b1;
          ctrl.mem_write_src = MEM_WRITE_SRC_REG;
          ctrl.alu_a_src     = ALU_SRC_REG;
          ctrl.alu_b_src     = ALU_SRC_IMM12;
          use_x_rs1          = 1'b1;
          use_x_rs2          = 1'b1;
        end
        OP_STORE_FP: begin
          ctrl.write_mem     = 1'b1;
          ctrl.mem_write_src = MEM_WRITE_SRC_XMM;
          ctrl.alu_a_src     = ALU_SRC_REG;
          ctrl.alu_b_src     = ALU_SRC_IMM12;
          use_x_rs1          = 1'b1;
          use_xmm_rs2        = 1'b1;
        end
        OP_OP: begin
          ctrl.write_reg     = 1'b1;
          ctrl.reg_write_src = REG_WRITE_SRC_ALU;
          ctrl.alu_a_src     = ALU_SRC_REG;
          ctrl.alu_b_src     = ALU_SRC_REG;
          use_x_rs1          = 1'b1;
          use_x_rs2          = 1'b1;
        end
        OP_LUI: begin
          ctrl.write_reg     = 1'b1;
          ctrl.reg_write_src = REG_WRITE_SRC_ALU;
          ctrl.alu_a_src     = ALU_SRC_ZERO;
          ctrl.alu_b_src     = ALU_SRC_IMM20;
        end
        OP_OP_FP: begin
          ctrl.write_xmm     = 1'b1;
          ctrl.xmm_write_src = XMM_WRITE_SRC_FPU;
          ctrl.fpu_a_src     = FPU_SRC_XMM;
          ctrl.fpu_b_src     = FPU_SRC_XMM;
          ctrl.fpu_c_src     = FPU_SRC_ONE;
          use_xmm_rs1        = 1'b1;
          use_xmm_rs2        = 1'b1;
        end
        OP_BRANCH: begin
          ctrl.alu_a_src = ALU_SRC_REG;
          ctrl.alu_b_src = ALU_SRC_REG;
          use_x_rs1      = 1'b1;
          use_x_rs2      = 1'b1;
        end
        OP_JALR: begin
          ctrl.write_reg     = 1'b1;
          ctrl.reg_write_src = REG_WRITE_SRC_ALU;
          ctrl.alu_a_src     = ALU_SRC_PC_PLUS4;
          ctrl.alu_b_src     = ALU_SRC_ZERO;
          use_x_rs1          = 1'b1;
        end
        OP_JAL: begin
          ctrl.write_reg     = 1'b1;
          ctrl.reg_write_src = REG_WRITE_SRC_ALU;
          ctrl.alu_a_src     = ALU_SRC_PC_PLUS4;
          ctrl.alu_b_src     = ALU_SRC_ZERO;
        end
        default: ctrl.illegal = 1'b1;
      endcase

      // Without the FP unit these opcodes are reserved: clear everything decoded above.
      if (!FP_EN && is_fp_opcode(opcode[6:2])) begin
        ctrl         = '0;
        ctrl.illegal = 1'b1;
        use_x_rs1    = 1'b0;
        use_xmm_rs2  = 1'b0;
        use_xmm_rs1  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: one-entry output register, valid/ready handshake and a pending-write
// scoreboard for the x and xmm register files that stalls issue on RAW/WAW hazards.
module decode_issue_stage
  import ctrl_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned XLEN     = 32,
  parameter bit          FP_EN    = 1'b1,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [ADDR_W-1:0] out_rs1,
  output logic [ADDR_W-1:0] out_rs2,
  output logic [ADDR_W-1:0] out_rs3,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_read_mem,
  output logic              out_write_mem,
  output logic              out_write_reg,
  output logic              out_write_xmm,
  output logic              out_illegal,
  output logic [2:0]        out_alu_a_src,
  output logic [2:0]        out_alu_b_src,
  output logic [1:0]        out_fpu_a_src,
  output logic [1:0]        out_fpu_b_src,
  output logic [1:0]        out_fpu_c_src,
  output logic [2:0]        out_reg_write_src,
  output logic [2:0]        out_xmm_write_src,
  output logic [1:0]        out_mem_write_src,
  input  logic              wb_reg_valid,
  input  logic [ADDR_W-1:0] wb_reg_addr,
  input  logic              wb_xmm_valid,
  input  logic [ADDR_W-1:0] wb_xmm_addr,
  input  logic              flush
);

  ctrl_bundle_t dec;
  logic         use_x_rs1, use_x_rs2, use_xmm_rs1, use_xmm_rs2;

  logic [ADDR_W-1:0] rs1, rs2, rs3, rd;
  assign rs1 = in_instr[15 +: ADDR_W];
  assign rs2 = in_instr[20 +: ADDR_W];
  assign rs3 = in_instr[27 +: ADDR_W];
  assign rd  = in_instr[7 +: ADDR_W];

  logic unused_instr_bits;
  assign unused_instr_bits = ^{in_instr[14:12], in_instr[26:25]};

  instr_ctrl_decode #(
    .FP_EN(FP_EN)
  ) u_decode (
    .opcode     (in_instr[6:0]),
    .ctrl       (dec),
    .use_x_rs1  (use_x_rs1),
    .use_x_rs2  (use_x_rs2),
    .use_xmm_rs1(use_xmm_rs1),
    .use_xmm_rs2(use_xmm_rs2)
  );

  logic                valid_q;
  ctrl_bundle_t        ctrl_q;
  logic [XLEN-1:0]     pc_q;
  logic [ADDR_W-1:0]   rs1_q, rs2_q, rs3_q, rd_q;
  logic [NUM_REGS-1:0] pend_x, pend_x_d;
  logic [NUM_REGS-1:0] pend_xmm, pend_xmm_d;

  logic dst_x, dst_xmm, held_x, held_xmm, hazard, accept;

  // x0 is hard-wired, so it never becomes a tracked destination.
  assign dst_x    = dec.write_reg & (rd != '0);
  assign dst_xmm  = dec.write_xmm;
  assign held_x   = valid_q & ctrl_q.write_reg & (rd_q != '0);
  assign held_xmm = valid_q & ctrl_q.write_xmm;

  assign hazard = (use_x_rs1   & pend_x[rs1])   | (use_x_rs2   & pend_x[rs2])   |
                  (use_xmm_rs1 & pend_xmm[rs1]) | (use_xmm_rs2 & pend_xmm[rs2]) |
                  (dst_x & pend_x[rd]) | (dst_xmm & pend_xmm[rd]);

  assign in_ready = (!valid_q | out_ready) & !hazard & !flush;
  assign accept   = in_valid & in_ready;

  // Ordering gives set priority over a same-cycle write-back clear.
  always_comb begin
    pend_x_d   = pend_x;
    pend_xmm_d = pend_xmm;
    if (wb_reg_valid) pend_x_d[wb_reg_addr] = 1'b0;
    if (wb_xmm_valid) pend_xmm_d[wb_xmm_addr] = 1'b0;
    if (flush && held_x) pend_x_d[rd_q] = 1'b0;
    if (flush && held_xmm) pend_xmm_d[rd_q] = 1'b0;
    if (accept && dst_x) pend_x_d[rd] = 1'b1;
    if (accept && dst_xmm) pend_xmm_d[rd] = 1'b1;
    pend_x_d[0] = 1'b0;
    if (!FP_EN) pend_xmm_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      pc_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rs3_q    <= '0;
      rd_q     <= '0;
      pend_x   <= '0;
      pend_xmm <= '0;
    end else begin
      pend_x   <= pend_x_d;
      pend_xmm <= pend_xmm_d;
      if (flush) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b1;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
      if (accept) begin
        ctrl_q <= dec;
        pc_q   <= in_pc;
        rs1_q  <= rs1;
        rs2_q  <= rs2;
        rs3_q  <= rs3;
        rd_q   <= rd;
      end
    end
  end

  assign out_valid         = valid_q;
  assign out_pc            = pc_q;
  assign out_rs1           = rs1_q;
  assign out_rs2           = rs2_q;
  assign out_rs3           = rs3_q;
  assign out_rd            = rd_q;
  assign out_read_mem      = ctrl_q.read_mem;
  assign out_write_mem     = ctrl_q.write_mem;
  assign out_write_reg     = ctrl_q.write_reg;
  assign out_write_xmm     = ctrl_q.write_xmm;
  assign out_illegal       = ctrl_q.illegal;
  assign out_alu_a_src     = ctrl_q.alu_a_src;
  assign out_alu_b_src     = ctrl_q.alu_b_src;
  assign out_fpu_a_src     = ctrl_q.fpu_a_src;
  assign out_fpu_b_src     = ctrl_q.fpu_b_src;
  assign out_fpu_c_src     = ctrl_q.fpu_c_src;
  assign out_reg_write_src = ctrl_q.reg_write_src;
  assign out_xmm_write_src = ctrl_q.xmm_write_src;
  assign out_mem_write_src = ctrl_q.mem_write_src;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Self-checking bench for decode_issue_stage: directed scenarios plus randomized traffic
// checked against a cycle-level reference model of the issue rules.
module tb_decode_issue_stage;
  import ctrl_pkg::*;

  logic clk, reset, in_valid, in_ready, out_valid, out_ready, flush;
  logic [31:0] in_instr, in_pc, out_pc;
  logic [4:0] out_rs1, out_rs2, out_rs3, out_rd, wb_reg_addr, wb_xmm_addr;
  logic out_read_mem, out_write_mem, out_write_reg, out_write_xmm, out_illegal;
  logic [2:0] out_alu_a_src, out_alu_b_src, out_reg_write_src, out_xmm_write_src;
  logic [1:0] out_fpu_a_src, out_fpu_b_src, out_fpu_c_src, out_mem_write_src;
  logic wb_reg_valid, wb_xmm_valid;

  logic nf_in_ready, nf_out_valid, nf_rm, nf_wm, nf_wr, nf_wx, nf_ill;
  logic [31:0] nf_pc;
  logic [4:0] nf_rs1, nf_rs2, nf_rs3, nf_rd;
  logic [2:0] nf_aa, nf_ab, nf_rws, nf_xws;
  logic [1:0] nf_fa, nf_fb, nf_fc, nf_mws;

  int checks = 0;
  int errors = 0;

  decode_issue_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rs3(out_rs3), .out_rd(out_rd),
    .out_read_mem(out_read_mem), .out_write_mem(out_write_mem),
    .out_write_reg(out_write_reg), .out_write_xmm(out_write_xmm), .out_illegal(out_illegal),
    .out_alu_a_src(out_alu_a_src), .out_alu_b_src(out_alu_b_src),
    .out_fpu_a_src(out_fpu_a_src), .out_fpu_b_src(out_fpu_b_src),
    .out_fpu_c_src(out_fpu_c_src), .out_reg_write_src(out_reg_write_src),
    .out_xmm_write_src(out_xmm_write_src), .out_mem_write_src(out_mem_write_src),
    .wb_reg_valid(wb_reg_valid), .wb_reg_addr(wb_reg_addr),
    .wb_xmm_valid(wb_xmm_valid), .wb_xmm_addr(wb_xmm_addr), .flush(flush)
  );

  decode_issue_stage #(.FP_EN(1'b0)) dut_nofp (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(nf_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(nf_out_valid), .out_ready(1'b1),
    .out_pc(nf_pc), .out_rs1(nf_rs1), .out_rs2(nf_rs2), .out_rs3(nf_rs3), .out_rd(nf_rd),
    .out_read_mem(nf_rm), .out_write_mem(nf_wm), .out_write_reg(nf_wr),
    .out_write_xmm(nf_wx), .out_illegal(nf_ill), .out_alu_a_src(nf_aa), .out_alu_b_src(nf_ab),
    .out_fpu_a_src(nf_fa), .out_fpu_b_src(nf_fb), .out_fpu_c_src(nf_fc),
    .out_reg_write_src(nf_rws), .out_xmm_write_src(nf_xws), .out_mem_write_src(nf_mws),
    .wb_reg_valid(wb_reg_valid), .wb_reg_addr(wb_reg_addr),
    .wb_xmm_valid(wb_xmm_valid), .wb_xmm_addr(wb_xmm_addr), .flush(1'b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (actual running, required done)");
    $fatal(1);
  end

  logic [76:0] obs;
  assign obs = {out_pc, out_rs1, out_rs2, out_rs3, out_rd, out_read_mem, out_write_mem,
                out_write_reg, out_write_xmm, out_illegal, out_alu_a_src, out_alu_b_src,
                out_fpu_a_src, out_fpu_b_src, out_fpu_c_src, out_reg_write_src,
                out_xmm_write_src, out_mem_write_src};

  typedef struct packed {
    bit [31:0] pc;
    bit [4:0]  rs1, rs2, rs3, rd;
    bit        rm, wm, wr, wx, ill;
    bit [2:0]  aa, ab;
    bit [1:0]  fa, fb, fc;
    bit [2:0]  rws, xws;
    bit [1:0]  mws;
    bit        ux1, ux2, uf1, uf2;
  } exp_t;

  // Reference model state
  bit        m_valid;
  exp_t      m_out;
  bit [31:0] m_px, m_pf;

  function automatic bit [31:0] enc(bit [4:0] op, bit [4:0] rd, bit [4:0] rs1, bit [4:0] rs2,
                                    bit [4:0] rs3);
    return {rs3, 2'b00, rs2, rs1, 3'b000, rd, op, 2'b11};
  endfunction

  function automatic exp_t ref_decode(bit [31:0] ins, bit [31:0] pc, bit fp);
    exp_t e;
    e = '0;
    e.pc = pc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rs3 = ins[31:27]; e.rd = ins[11:7];
    if (ins[1:0] != 2'b11) begin
      e.ill = 1;
      return e;
    end
    case (ins[6:2])
      5'h00: begin e.rm = 1; e.wr = 1; e.rws = REG_WRITE_SRC_MEM;
                   e.aa = ALU_SRC_REG; e.ab = ALU_SRC_IMM12; e.ux1 = 1; end
      5'h01: begin e.rm = 1; e.wx = 1; e.xws = XMM_WRITE_SRC_MEM;
                   e.aa = ALU_SRC_REG; e.ab = ALU_SRC_IMM12; e.ux1 = 1; end
      5'h03: ;
      5'h04: begin e.wr = 1; e.rws = REG_WRITE_SRC_ALU;
                   e.aa = ALU_SRC_REG; e.ab = ALU_SRC_IMM12; e.ux1 = 1; end
      5'h05: begin e.wr = 1; e.rws = REG_WRITE_SRC_ALU; e.aa = ALU_SRC_PC; e.ab = ALU_SRC_IMM20; end
      5'h08: begin e.wm = 1; e.mws = MEM_WRITE_SRC_REG;
                   e.aa = ALU_SRC_REG; e.ab = ALU_SRC_IMM12; e.ux1 = 1; e.ux2 = 1; end
      5'h09: begin e.wm = 1; e.mws = MEM_WRITE_SRC_XMM;
                   e.aa = ALU_SRC_REG; e.ab = ALU_SRC_IMM12; e.ux1 = 1; e.uf2 = 1; end
      5'h0c: begin e.wr = 1; e.rws = REG_WRITE_SRC_ALU;
                   e.aa = ALU_SRC_REG; e.ab = ALU_SRC_REG; e.ux1 = 1; e.ux2 = 1; end
      5'h0d: begin e.wr = 1; e.rws = REG_WRITE_SRC_ALU; e.aa = ALU_SRC_ZERO; e.ab = ALU_SRC_IMM20; end
      5'h14: begin e.wx = 1; e.xws = XMM_WRITE_SRC_FPU; e.fa = FPU_SRC_XMM; e.fb = FPU_SRC_XMM;
                   e.fc = FPU_SRC_ONE; e.uf1 = 1; e.uf2 = 1; end
      5'h18: begin e.aa = ALU_SRC_REG; e.ab = ALU_SRC_REG; e.ux1 = 1; e.ux2 = 1; end
      5'h19: begin e.wr = 1; e.rws = REG_WRITE_SRC_ALU;
                   e.aa = ALU_SRC_PC_PLUS4; e.ab = ALU_SRC_ZERO; e.ux1 = 1; end
      5'h1b: begin e.wr = 1; e.rws = REG_WRITE_SRC_ALU; e.aa = ALU_SRC_PC_PLUS4; e.ab = ALU_SRC_ZERO; end
      default: e.ill = 1;
    endcase
    if (!fp && (ins[6:2] == 5'h01 || ins[6:2] == 5'h09 || ins[6:2] == 5'h14)) begin
      e = '0;
      e.pc = pc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rs3 = ins[31:27]; e.rd = ins[11:7];
      e.ill = 1;
    end
    return e;
  endfunction

  function automatic bit [76:0] pack_exp(exp_t e);
    return {e.pc, e.rs1, e.rs2, e.rs3, e.rd, e.rm, e.wm, e.wr, e.wx, e.ill, e.aa, e.ab,
            e.fa, e.fb, e.fc, e.rws, e.xws, e.mws};
  endfunction

  function automatic bit exp_ready();
    exp_t d;
    bit hz;
    d  = ref_decode(in_instr, in_pc, 1'b1);
    hz = (d.ux1 && m_px[d.rs1]) || (d.ux2 && m_px[d.rs2]) || (d.uf1 && m_pf[d.rs1]) ||
         (d.uf2 && m_pf[d.rs2]) || (d.wr && d.rd != 0 && m_px[d.rd]) || (d.wx && m_pf[d.rd]);
    return (!m_valid || out_ready) && !hz && !flush;
  endfunction

  // Advance one clock, stepping the reference model with the inputs currently driven.
  task automatic tick();
    exp_t d;
    bit   acc;
    d   = ref_decode(in_instr, in_pc, 1'b1);
    acc = in_valid && exp_ready();
    @(posedge clk);
    if (reset) begin
      m_valid = 0; m_out = '0; m_px = 0; m_pf = 0;
    end else begin
      if (wb_reg_valid) m_px[wb_reg_addr] = 0;
      if (wb_xmm_valid) m_pf[wb_xmm_addr] = 0;
      if (flush && m_valid) begin
        if (m_out.wr && m_out.rd != 0) m_px[m_out.rd] = 0;
        if (m_out.wx) m_pf[m_out.rd] = 0;
      end
      if (acc && d.wr && d.rd != 0) m_px[d.rd] = 1;
      if (acc && d.wx) m_pf[d.rd] = 1;
      if (flush) m_valid = 0;
      else if (acc) begin m_valid = 1; m_out = d; end
      else if (out_ready) m_valid = 0;
    end
    #1;
  endtask

  task automatic drive_idle();
    in_valid = 0; flush = 0; wb_reg_valid = 0; wb_xmm_valid = 0;
    wb_reg_addr = 0; wb_xmm_addr = 0; reset = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    drive_idle();
    in_instr = 32'h0; in_pc = 32'h0; out_ready = 0;
    reset = 1;
    tick();
    reset = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid actual %b required 0", out_valid); end
    checks++; if (obs !== 77'd0) begin errors++;
      $display("FAIL reset_fields actual %h required 0", obs); end
    checks++; if (dut.pend_x !== 32'h0 || dut.pend_xmm !== 32'h0) begin errors++;
      $display("FAIL reset_pend actual %h/%h required 0/0", dut.pend_x, dut.pend_xmm); end
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL reset_in_ready actual %b required 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1;
    in_valid = 1; in_pc = 32'h100; in_instr = enc(5'h04, 5'd1, 5'd0, 5'd0, 5'd0);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL b2b_ready1 actual %b required 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_rd !== 5'd1 || out_pc !== 32'h100) begin errors++;
      $display("FAIL b2b_first actual v=%b rd=%0d pc=%h required v=1 rd=1 pc=100",
               out_valid, out_rd, out_pc); end
    in_pc = 32'h104; in_instr = enc(5'h04, 5'd2, 5'd0, 5'd0, 5'd0);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL b2b_ready2 actual %b required 1", in_ready); end
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_rd !== 5'd2 || out_write_reg !== 1'b1) begin errors++;
      $display("FAIL b2b_second actual v=%b rd=%0d wr=%b required v=1 rd=2 wr=1",
               out_valid, out_rd, out_write_reg); end
    checks++; if (dut.pend_x !== 32'h6) begin errors++;
      $display("FAIL b2b_pend actual %h required 6", dut.pend_x); end
    wb_reg_valid = 1; wb_reg_addr = 1; tick();
    wb_reg_addr = 2; tick();
    wb_reg_valid = 0;
  endtask

  task automatic test_raw_stall();
    out_ready = 1;
    in_valid = 1; in_instr = enc(5'h04, 5'd5, 5'd0, 5'd0, 5'd0);
    tick();
    in_instr = enc(5'h0c, 5'd6, 5'd5, 5'd5, 5'd0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++;
        $display("FAIL raw_stall cycle %0d actual %b required 0", i, in_ready); end
      tick();
    end
    wb_reg_valid = 1; wb_reg_addr = 5;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL raw_no_bypass actual %b required 0", in_ready); end
    tick();
    wb_reg_valid = 0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL raw_release actual %b required 1", in_ready); end
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_rd !== 5'd6 || out_rs1 !== 5'd5) begin errors++;
      $display("FAIL raw_issue actual v=%b rd=%0d rs1=%0d required v=1 rd=6 rs1=5",
               out_valid, out_rd, out_rs1); end
    wb_reg_valid = 1; wb_reg_addr = 6; tick();
    wb_reg_valid = 0;
  endtask

  task automatic test_fp_hazard();
    out_ready = 1;
    in_valid = 1; in_instr = enc(5'h14, 5'd3, 5'd1, 5'd2, 5'd0);
    tick();
    checks++; if (dut.pend_xmm !== 32'h8 || out_write_xmm !== 1'b1 ||
                  out_fpu_c_src !== FPU_SRC_ONE) begin errors++;
      $display("FAIL fp_opfp actual pend=%h wx=%b fc=%0d required pend=8 wx=1 fc=%0d",
               dut.pend_xmm, out_write_xmm, out_fpu_c_src, FPU_SRC_ONE); end
    in_instr = enc(5'h09, 5'd0, 5'd4, 5'd3, 5'd0);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL fp_stall actual %b required 0", in_ready); end
    tick();
    wb_xmm_valid = 1; wb_xmm_addr = 3;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL fp_no_bypass actual %b required 0", in_ready); end
    tick();
    wb_xmm_valid = 0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL fp_release actual %b required 1", in_ready); end
    tick();
    in_valid = 0;
    checks++; if (out_write_mem !== 1'b1 || out_mem_write_src !== MEM_WRITE_SRC_XMM ||
                  dut.pend_xmm !== 32'h0) begin errors++;
      $display("FAIL fp_store actual wm=%b mws=%0d pend=%h required wm=1 mws=%0d pend=0",
               out_write_mem, out_mem_write_src, dut.pend_xmm, MEM_WRITE_SRC_XMM); end
  endtask

  task automatic test_fp_disabled();
    do_reset();
    out_ready = 1;
    in_valid = 1; in_instr = enc(5'h14, 5'd3, 5'd1, 5'd2, 5'd0);
    #1;
    checks++; if (nf_in_ready !== 1'b1) begin errors++;
      $display("FAIL nofp_ready actual %b required 1", nf_in_ready); end
    tick();
    checks++; if (nf_out_valid !== 1'b1 || nf_ill !== 1'b1 ||
                  {nf_rm, nf_wm, nf_wr, nf_wx} !== 4'b0 || {nf_fa, nf_fb, nf_fc, nf_xws} !== 9'b0)
    begin errors++;
      $display("FAIL nofp_opfp actual v=%b ill=%b en=%b required v=1 ill=1 en=0000",
               nf_out_valid, nf_ill, {nf_rm, nf_wm, nf_wr, nf_wx}); end
    in_instr = enc(5'h01, 5'd4, 5'd1, 5'd0, 5'd0);
    tick();
    in_valid = 0;
    checks++; if (nf_ill !== 1'b1 || nf_rm !== 1'b0 || out_write_xmm !== 1'b1) begin errors++;
      $display("FAIL nofp_loadfp actual ill=%b rm=%b fp_wx=%b required ill=1 rm=0 fp_wx=1",
               nf_ill, nf_rm, out_write_xmm); end
  endtask

  task automatic test_illegal();
    do_reset();
    out_ready = 1;
    in_valid = 1; in_instr = 32'h0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 ||
                  {out_read_mem, out_write_mem, out_write_reg, out_write_xmm} !== 4'b0 ||
                  dut.pend_x !== 32'h0) begin errors++;
      $display("FAIL illegal_zero actual v=%b ill=%b pend=%h required v=1 ill=1 pend=0",
               out_valid, out_illegal, dut.pend_x); end
    in_instr = enc(5'h0d, 5'd0, 5'd0, 5'd0, 5'd0);
    tick();
    checks++; if (out_illegal !== 1'b0 || out_write_reg !== 1'b1 || dut.pend_x !== 32'h0)
    begin errors++;
      $display("FAIL lui_x0 actual ill=%b wr=%b pend=%h required ill=0 wr=1 pend=0",
               out_illegal, out_write_reg, dut.pend_x); end
    in_instr = enc(5'h1c, 5'd9, 5'd0, 5'd0, 5'd0);
    tick();
    in_valid = 0;
    checks++; if (out_illegal !== 1'b1 || out_write_reg !== 1'b0 || dut.pend_x !== 32'h0)
    begin errors++;
      $display("FAIL illegal_op actual ill=%b wr=%b pend=%h required ill=1 wr=0 pend=0",
               out_illegal, out_write_reg, dut.pend_x); end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 0;
    in_valid = 1; in_instr = enc(5'h00, 5'd7, 5'd1, 5'd0, 5'd0);
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || dut.pend_x !== 32'h80) begin errors++;
      $display("FAIL flush_load actual v=%b pend=%h required v=1 pend=80", out_valid, dut.pend_x);
    end
    tick();
    checks++; if (out_valid !== 1'b1 || out_rd !== 5'd7 || out_read_mem !== 1'b1) begin errors++;
      $display("FAIL flush_hold actual v=%b rd=%0d rm=%b required v=1 rd=7 rm=1",
               out_valid, out_rd, out_read_mem); end
    flush = 1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL flush_ready actual %b required 0", in_ready); end
    tick();
    flush = 0;
    checks++; if (out_valid !== 1'b0 || dut.pend_x !== 32'h0) begin errors++;
      $display("FAIL flush_drop actual v=%b pend=%h required v=0 pend=0", out_valid, dut.pend_x);
    end
    out_ready = 1;
    in_valid = 1; in_instr = enc(5'h04, 5'd7, 5'd0, 5'd0, 5'd0);
    wb_reg_valid = 1; wb_reg_addr = 7;
    tick();
    in_valid = 0; wb_reg_valid = 0;
    checks++; if (dut.pend_x[7] !== 1'b1) begin errors++;
      $display("FAIL set_beats_clear actual %b required 1", dut.pend_x[7]); end
  endtask

  task automatic test_reset_mid();
    out_ready = 0;
    in_valid = 1; in_instr = enc(5'h0c, 5'd8, 5'd7, 5'd7, 5'd0);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++;
      $display("FAIL midreset_stall actual %b required 0", in_ready); end
    tick();
    reset = 1;
    tick();
    reset = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || dut.pend_x !== 32'h0 || dut.pend_xmm !== 32'h0 ||
                  in_ready !== 1'b1) begin errors++;
      $display("FAIL midreset actual v=%b px=%h pf=%h rdy=%b required v=0 px=0 pf=0 rdy=1",
               out_valid, dut.pend_x, dut.pend_xmm, in_ready); end
    in_valid = 0;
  endtask

  task automatic test_random();
    bit [4:0] ops [13] = '{5'h00, 5'h01, 5'h03, 5'h04, 5'h05, 5'h08, 5'h09, 5'h0c, 5'h0d,
                           5'h14, 5'h18, 5'h19, 5'h1b};
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      out_ready    = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 19) == 0);
      reset        = ($urandom_range(0, 199) == 0);
      wb_reg_valid = ($urandom_range(0, 2) == 0);
      wb_xmm_valid = ($urandom_range(0, 2) == 0);
      wb_reg_addr  = 5'($urandom_range(0, 7));
      wb_xmm_addr  = 5'($urandom_range(0, 7));
      in_pc        = $urandom();
      if ($urandom_range(0, 9) == 0) in_instr = $urandom();
      else in_instr = enc(ops[$urandom_range(0, 12)], 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom));
      #1;
      checks++; if (in_ready !== exp_ready()) begin errors++;
        $display("FAIL rand_ready cycle %0d actual %b required %b", n, in_ready, exp_ready()); end
      tick();
      checks++; if (out_valid !== m_valid || obs !== pack_exp(m_out)) begin errors++;
        $display("FAIL rand_out cycle %0d actual v=%b %h required v=%b %h",
                 n, out_valid, obs, m_valid, pack_exp(m_out)); end
      checks++; if (dut.pend_x !== m_px || dut.pend_xmm !== m_pf) begin errors++;
        $display("FAIL rand_pend cycle %0d actual %h/%h required %h/%h",
                 n, dut.pend_x, dut.pend_xmm, m_px, m_pf); end
    end
    drive_idle();
  endtask

  initial begin
    m_valid = 0; m_out = '0; m_px = 0; m_pf = 0;
    test_reset();
    test_back_to_back();
    test_raw_stall();
    test_fp_hazard();
    test_fp_disabled();
    test_illegal();
    test_flush();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
